hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Hazard and stall controller for the 5-stage pipeline (fetch, decode, execute, memory_rw, writeback_reg).
- Generates the operand-forwarding selects for the execute stage. Also generates load-use stalls and branch/jump flushes.
- Runs a wait-state FSM that freezes the pipeline while a variable-latency data memory completes a request, with a timeout and sticky error.
- Keeps saturating stall and flush performance counters.
- Sits at top level beside the five stage modules. Its stall, flush and forward outputs drive the stage enables, stage clears and execute-stage operand muxes.

Parameters:
- MEM_TIMEOUT, 16, max cycles a single data-memory request may wait for ack before being abandoned (≥2).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- Rs1D  in  5  rs1 of instruction in decode
- Rs2D  in  5  rs2 of instruction in decode
- Rs1E  in  5  rs1 of instruction in execute
- Rs2E  in  5  rs2 of instruction in execute
- RdE  in  5  destination register in execute
- ResultSrcE  in  1  1 = load instruction in execute
- PCSrcE  in  1  branch taken / jump in execute
- RdM  in  5  destination register in memory stage
- RegWriteM  in  1  memory-stage instruction writes rd
- MemReqM  in  1  memory-stage instruction accesses data memory
- MemAckM  in  1  data memory completes the access this cycle
- RdW  in  5  destination register in writeback
- RegWriteW  in  1  writeback instruction writes rd
- ForwardAE  out  2  operand A select: 00 regfile, 01 ResultW, 10 ALUResultM
- ForwardBE  out  2  operand B select, same encoding
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID register
- StallE  out  1  hold ID/EX register
- StallM  out  1  hold EX/MEM register
- FlushD  out  1  clear IF/ID register
- FlushE  out  1  clear ID/EX register
- FlushW  out  1  clear MEM/WB register (insert bubble)
- MemErr  out  1  sticky: a request timed out
- StallCount  out  CNT_W  cycles with StallF=1
- FlushCount  out  CNT_W  cycles with FlushD or FlushE = 1

Behaviour:
- Reset, asynchronous, active-high:
  - FSM goes to IDLE, wait counter 0, MemErr 0, StallCount 0, FlushCount 0.
  - While rst=1 all stall/flush outputs are 0 and the forward selects are 00.
- Forwarding (combinational, 0 latency):
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Otherwise ForwardAE=01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Otherwise ForwardAE=00.
  - The memory stage has priority over writeback. ForwardBE is identical using Rs2E.
- Load-use hazard: lwStall = ResultSrcE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D) && !PCSrcE.
- Branch redirect wins over load-use: a taken branch squashes the decode instruction, so no stall is needed.
- Memory wait: memStall = MemReqM && !MemAckM && !timeout.
- FSM, 2 states:
  - IDLE -> WAIT when memStall; the wait counter loads 1.
  - WAIT: the counter increments each cycle while memStall holds.
  - WAIT -> IDLE on MemAckM, or on MemReqM dropping (counter cleared).
  - timeout = (state==WAIT && counter==MEM_TIMEOUT-1 && !MemAckM). On timeout, MemErr sets (held until rst), memStall deasserts that cycle, and the FSM returns to IDLE.
  - A request spanning exactly MEM_TIMEOUT cycles with ack on the last cycle is not an error.
- Output equations, in priority order:
  - memStall=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. Load-use and branch are ignored because the E stage is frozen and PCSrcE re-presents after release.
  - Otherwise: StallF=StallD=lwStall, StallE=StallM=0, FlushD=PCSrcE, FlushE=PCSrcE|lwStall, FlushW=0.
- Back-to-back memory requests: each new request starts a fresh count from IDLE.
- Counters:
  - StallCount increments in any cycle with StallF=1.
  - FlushCount increments in any cycle with FlushD|FlushE=1.
  - Both saturate at all-ones and never wrap.
- rst asserted mid-WAIT aborts immediately to IDLE with no MemErr.

Decomposition:
- Package hazard_pkg holds:
  - Forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - FSM state encoding MEM_IDLE/MEM_WAIT.
- Sub-module forward_select_unit: combinational M/W compare for one source register. Instantiated twice, for operands A and B.
- FSM, counters and stall/flush logic stay in hazard_control_unit.

Test Plan:
- Forward priority: RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=5 -> ForwardAE=ForwardBE=10. With RegWriteM=0 -> 01. With RdM=RdW=0 -> 00.
- Load-use: ResultSrcE=1, RdE=3, Rs2D=3, PCSrcE=0 -> StallF=StallD=FlushE=1, FlushD=0 for one cycle; StallCount 0→1.
- Branch vs load-use: same as above plus PCSrcE=1 -> StallF=0, FlushD=FlushE=1; FlushCount increments.
- Memory wait: MemReqM=1, ack after 3 cycles -> StallF/D/E/M and FlushW high for exactly 3 cycles, low on the ack cycle; MemErr=0.
- Timeout: MEM_TIMEOUT=4, MemReqM held and never acked -> stall for 3 cycles, released on the 4th with MemErr=1 from the next edge, held until rst.
- Async reset mid-WAIT: assert rst between clock edges -> outputs 0, counters 0, FSM IDLE immediately. With PCSrcE=1 held during a memory stall, FlushD/FlushE stay 0 until the stall releases, then assert.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard/stall controller.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  // A later stage can supply an operand only if it writes a non-x0 register that matches.
  function automatic logic reg_match(input logic [4:0] rd, input logic we, input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/forward_select_unit.sv
// Execute-stage operand forwarding select for one source register.
module forward_select_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);

  // Memory stage holds the newer value, so it takes priority over writeback.
  always_comb begin
    fwd = FWD_RF;
    if (reg_match(rd_m, reg_write_m, rs)) begin
      fwd = FWD_MEM;
    end else if (reg_match(rd_w, reg_write_w, rs)) begin
      fwd = FWD_WB;
    end else begin
      fwd = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Forwarding, load-use stall, branch flush, data-memory wait FSM with timeout,
// and saturating stall/flush performance counters for the 5-stage pipeline.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic             MemReqM,
  input  logic             MemAckM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int WCW = $clog2(MEM_TIMEOUT) + 1;

  mem_state_t     state;
  logic [WCW-1:0] wait_cnt;
  logic [1:0]     fwd_a;
  logic [1:0]     fwd_b;
  logic           lw_stall;
  logic           timeout;
  logic           mem_stall;

  forward_select_unit u_fwd_a (
    .rs(Rs1E), .rd_m(RdM), .reg_write_m(RegWriteM),
    .rd_w(RdW), .reg_write_w(RegWriteW), .fwd(fwd_a)
  );

  forward_select_unit u_fwd_b (
    .rs(Rs2E), .rd_m(RdM), .reg_write_m(RegWriteM),
    .rd_w(RdW), .reg_write_w(RegWriteW), .fwd(fwd_b)
  );

  assign ForwardAE = rst ? FWD_RF : fwd_a;
  assign ForwardBE = rst ? FWD_RF : fwd_b;

  // A taken branch squashes the decode instruction, so it cancels the load-use stall.
  assign lw_stall  = ResultSrcE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;
  assign timeout   = (state == MEM_WAIT) && (wait_cnt == WCW'(MEM_TIMEOUT - 1)) && !MemAckM;
  assign mem_stall = MemReqM && !MemAckM && !timeout;

  // Memory freeze outranks load-use and branch: E is held, so PCSrcE re-presents on release.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (rst) begin
      StallF = 1'b0;
    end else if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = lw_stall;
      StallD = lw_stall;
      FlushD = PCSrcE;
      FlushE = PCSrcE | lw_stall;
    end
  end

  // Wait-state FSM: wait_cnt counts stalled cycles of the current request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MEM_IDLE;
      wait_cnt <= '0;
      MemErr   <= 1'b0;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= WCW'(1);
          end
        end
        MEM_WAIT: begin
          if (timeout) begin
            state    <= MEM_IDLE;
            wait_cnt <= '0;
            MemErr   <= 1'b1;
          end else if (MemAckM || !MemReqM) begin
            state    <= MEM_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        default: begin
          state    <= MEM_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallF && (StallCount != {CNT_W{1'b1}})) begin
        StallCount <= StallCount + CNT_W'(1);
      end
      if ((FlushD || FlushE) && (FlushCount != {CNT_W{1'b1}})) begin
        FlushCount <= FlushCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with a per-cycle reference model.
module tb_hazard_control_unit;

  localparam int TO  = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic ResultSrcE, PCSrcE, RegWriteM, MemReqM, MemAckM, RegWriteW;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [CW-1:0] StallCount, FlushCount;

  int vectors = 0;
  int miscompares = 0;

  hazard_control_unit #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RegWriteM(RegWriteM),
    .MemReqM(MemReqM), .MemAckM(MemAckM), .RdW(RdW), .RegWriteW(RegWriteW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  // Reference model: age = stalled cycles already spent by the current request.
  int m_age = 0;
  int m_sc  = 0;
  int m_fc  = 0;
  bit m_err = 1'b0;
  int m_fa, m_fb;
  bit m_sf, m_sd, m_se, m_sm, m_fd, m_fe, m_fw, m_lw, m_ms;

  function automatic int fwd_model(input logic [4:0] rs);
    if (RegWriteM && RdM != 5'd0 && RdM == rs) return 2;
    if (RegWriteW && RdW != 5'd0 && RdW == rs) return 1;
    return 0;
  endfunction

  always_comb begin
    m_fa = 0; m_fb = 0;
    m_sf = 1'b0; m_sd = 1'b0; m_se = 1'b0; m_sm = 1'b0;
    m_fd = 1'b0; m_fe = 1'b0; m_fw = 1'b0;
    m_lw = ResultSrcE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D) && !PCSrcE;
    m_ms = MemReqM && !MemAckM && (m_age < TO - 1);
    if (!rst) begin
      m_fa = fwd_model(Rs1E);
      m_fb = fwd_model(Rs2E);
      if (m_ms) begin
        m_sf = 1'b1; m_sd = 1'b1; m_se = 1'b1; m_sm = 1'b1; m_fw = 1'b1;
      end else begin
        m_sf = m_lw; m_sd = m_lw; m_fd = PCSrcE; m_fe = PCSrcE || m_lw;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_age <= 0; m_err <= 1'b0; m_sc <= 0; m_fc <= 0;
    end else begin
      m_age <= m_ms ? m_age + 1 : 0;
      if (MemReqM && !MemAckM && !m_ms) m_err <= 1'b1;
      if (m_sf) m_sc <= (m_sc < SAT) ? m_sc + 1 : SAT;
      if (m_fd || m_fe) m_fc <= (m_fc < SAT) ? m_fc + 1 : SAT;
    end
  end

  task automatic cmp(input string nm, input int act, input int exp);
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    vectors++;
    cmp("ForwardAE", ForwardAE, m_fa);
    cmp("ForwardBE", ForwardBE, m_fb);
    cmp("StallF", StallF, m_sf);
    cmp("StallD", StallD, m_sd);
    cmp("StallE", StallE, m_se);
    cmp("StallM", StallM, m_sm);
    cmp("FlushD", FlushD, m_fd);
    cmp("FlushE", FlushE, m_fe);
    cmp("FlushW", FlushW, m_fw);
    cmp("MemErr", MemErr, m_err);
    cmp("StallCount", StallCount, m_sc);
    cmp("FlushCount", FlushCount, m_fc);
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    cmp(nm, act, exp);
  endtask

  task automatic idle_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    ResultSrcE = 1'b0; PCSrcE = 1'b0; RegWriteM = 1'b0; MemReqM = 1'b0; MemAckM = 1'b0;
    RegWriteW = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic load_use();
    ResultSrcE = 1'b1; RdE = 5'd3; Rs2D = 5'd3; Rs1D = 5'd8;
  endtask

  initial begin
    idle_inputs();
    #1 rst = 1'b1;
    RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5; PCSrcE = 1'b1; MemReqM = 1'b1;
    settle();
    chk("rst_fwdA", ForwardAE, 0);
    chk("rst_stallF", StallF, 0);
    chk("rst_flushD", FlushD, 0);
    chk("rst_stallcnt", StallCount, 0);
    tick(); tick();
    rst = 1'b0;
    idle_inputs();

    RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5; Rs1E = 5'd5; Rs2E = 5'd5;
    settle(); chk("fwd_mem_A", ForwardAE, 2); chk("fwd_mem_B", ForwardBE, 2);
    tick(); RegWriteM = 1'b0;
    settle(); chk("fwd_wb_A", ForwardAE, 1); chk("fwd_wb_B", ForwardBE, 1);
    tick(); RegWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0;
    settle(); chk("fwd_x0_A", ForwardAE, 0); chk("fwd_x0_B", ForwardBE, 0);
    tick(); RdM = 5'd7; Rs1E = 5'd7; RdW = 5'd9; Rs2E = 5'd9;
    settle(); chk("fwd_mix_A", ForwardAE, 2); chk("fwd_mix_B", ForwardBE, 1);

    tick(); idle_inputs(); load_use();
    settle();
    chk("lu_stallF", StallF, 1); chk("lu_stallD", StallD, 1);
    chk("lu_flushE", FlushE, 1); chk("lu_flushD", FlushD, 0); chk("lu_stallE", StallE, 0);
    tick(); idle_inputs();
    settle(); chk("lu_stallcnt", StallCount, 1); chk("lu_flushcnt", FlushCount, 1);

    tick(); load_use(); PCSrcE = 1'b1;
    settle(); chk("br_stallF", StallF, 0); chk("br_flushD", FlushD, 1); chk("br_flushE", FlushE, 1);
    tick(); idle_inputs();
    settle(); chk("br_flushcnt", FlushCount, 2); chk("br_stallcnt", StallCount, 1);

    tick(); MemReqM = 1'b1;
    settle(); chk("mw_stallM", StallM, 1); chk("mw_flushW", FlushW, 1);
    tick(); tick();
    tick(); MemAckM = 1'b1;
    settle(); chk("mw_ack_stallF", StallF, 0); chk("mw_ack_flushW", FlushW, 0);
    tick(); idle_inputs();
    settle(); chk("mw_memerr", MemErr, 0); chk("mw_stallcnt", StallCount, 4);

    tick(); MemReqM = 1'b1; MemAckM = 1'b1;
    tick(); MemAckM = 1'b0;
    tick(); MemAckM = 1'b1;
    tick(); idle_inputs();

    tick(); MemReqM = 1'b1;
    tick(); tick();
    tick(); MemAckM = 1'b1;
    settle(); chk("exact_stallF", StallF, 0);
    tick(); idle_inputs();
    settle(); chk("exact_memerr", MemErr, 0);

    tick(); MemReqM = 1'b1; PCSrcE = 1'b1;
    settle(); chk("pcs_flushD_hold", FlushD, 0); chk("pcs_flushE_hold", FlushE, 0);
    tick();
    tick(); MemAckM = 1'b1;
    settle(); chk("pcs_flushD_rel", FlushD, 1); chk("pcs_flushE_rel", FlushE, 1);
    tick(); idle_inputs();
    settle(); chk("pcs_stallcnt", StallCount, 10);

    tick(); load_use();
    repeat (8) tick();
    tick(); idle_inputs();
    settle(); chk("sat_stallcnt", StallCount, 15); chk("sat_flushcnt", FlushCount, 12);

    tick(); MemReqM = 1'b1;
    settle(); chk("to_stall", StallF, 1);
    tick(); tick(); tick();
    settle(); chk("to_release", StallF, 0); chk("to_err_pre", MemErr, 0);
    tick(); idle_inputs();
    settle(); chk("to_err_set", MemErr, 1);
    repeat (3) tick();
    settle(); chk("to_err_held", MemErr, 1);

    tick(); MemReqM = 1'b1;
    tick();
    settle();
    #1 rst = 1'b1;
    #1;
    chk("arst_stallF", StallF, 0); chk("arst_stallcnt", StallCount, 0);
    chk("arst_flushcnt", FlushCount, 0); chk("arst_memerr", MemErr, 0);
    @(posedge clk); #2;
    rst = 1'b0; idle_inputs();
    settle(); chk("post_rst_stallF", StallF, 0); chk("post_rst_memerr", MemErr, 0);
    tick(); MemReqM = 1'b1;
    tick(); MemAckM = 1'b1;
    tick(); idle_inputs();
    settle(); chk("post_rst_stallcnt", StallCount, 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
